// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit: FSM state
// encoding, datapath widths, PC increment and the fetch-queue entry layout.
package if_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_queue.sv
// Circular fetch queue holding {pc, inst} entries between the L1I response
// and decode. Head is read straight from the storage array and forced to
// zero while the queue is empty. Clear drops all entries in one cycle and
// wins over a simultaneous push or pop.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int CNT_W  = $clog2(QDEPTH) + 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_valid,
  output logic [ENTRY_W-1:0] o_head
);

  localparam int PTR_W = $clog2(QDEPTH);

  if_entry_t        r_mem [QDEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_full;

  assign w_full  = (r_count == CNT_W'(QDEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_count = r_count;
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= if_entry_t'(i_push_data);
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage in front of the L1 instruction cache. Holds the PC,
// presents it as tag/index/offset, issues one fetch per accepted request,
// queues the returning words with their PC and hands them to decode.
// A redirect flushes the queue and any pending response and pulses flush.
// Build option: define IF_FETCH_PERF_EN to add saturating perf counters
// (perf_fetch_cnt, perf_stall_cnt).
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          TNUM     = 21,
  parameter int          INUM     = 26 - TNUM,
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
  input  logic            clk,
  input  logic            rst,
  output logic [TNUM-1:0] tag_C_L1,
  output logic [INUM-1:0] index_C_L1,
  output logic [5:0]      offset,
  output logic            read_C_L1,
  output logic            flush,
  input  logic            stall,
  input  logic [31:0]     read_data_L1_C,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [31:0]     inst_pc
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int              CNT_W   = $clog2(QDEPTH) + 1;
  localparam logic [CNT_W:0]  OCC_MAX = (CNT_W+1)'(QDEPTH);

  if_state_t        r_state;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  r_resp_pc;
  logic             r_read;
  logic             r_flush;
  logic             r_resp_pend;

  logic             w_accept;
  logic             w_pop;
  logic             w_qvalid;
  logic             w_credit;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ_next;
  if_entry_t        w_push_entry;
  logic [ENTRY_W-1:0] w_head;
  if_entry_t        w_head_entry;

  assign w_accept = r_read && !stall;
  assign w_pop    = w_qvalid && inst_ready;

  // Slots that will be spoken for after this edge: queued entries plus the
  // response still in flight. A new request needs one free slot beyond that,
  // so a returning word can never find the queue full.
  assign w_occ_next = {1'b0, w_count} + (CNT_W+1)'(r_resp_pend)
                    - (CNT_W+1)'(w_pop) + (CNT_W+1)'(w_accept);
  assign w_credit   = (w_occ_next < OCC_MAX);

  assign tag_C_L1   = r_pc[31:32-TNUM];
  assign index_C_L1 = r_pc[31-TNUM:6];
  assign offset     = r_pc[5:0];
  assign read_C_L1  = r_read;
  assign flush      = r_flush;

  assign w_push_entry.pc   = r_resp_pc;
  assign w_push_entry.inst = read_data_L1_C;
  assign w_head_entry      = if_entry_t'(w_head);
  assign inst_valid        = w_qvalid;
  assign inst_data         = w_head_entry.inst;
  assign inst_pc           = w_head_entry.pc;

  // Fetch FSM with PC, response tracking and registered request/flush outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_read      <= 1'b0;
      r_flush     <= 1'b0;
      r_resp_pend <= 1'b0;
    end else if (redirect_valid) begin
      // Abandon any request (even one accepted this cycle) and any pending
      // response; the low address bits are forced to word alignment.
      r_state     <= S_REQ;
      r_pc        <= redirect_pc & ~32'h3;
      r_read      <= 1'b0;
      r_flush     <= 1'b1;
      r_resp_pend <= 1'b0;
    end else begin
      r_flush     <= 1'b0;
      r_resp_pend <= w_accept;
      if (w_accept) r_pc <= r_pc + PC_STEP;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_read  <= 1'b1;
        end
        S_REQ, S_HOLD: begin
          if (w_credit) begin
            r_state <= S_REQ;
            r_read  <= 1'b1;
          end else begin
            r_state <= S_HOLD;
            r_read  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  // Remember which PC the in-flight response belongs to.
  always_ff @(posedge clk) begin
    if (w_accept) r_resp_pc <= r_pc;
  end

  if_fetch_queue #(
    .QDEPTH (QDEPTH),
    .CNT_W  (CNT_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (redirect_valid),
    .i_push      (r_resp_pend),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (w_qvalid),
    .o_head      (w_head)
  );

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Saturating event counters; intentionally left running across redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept && (r_perf_fetch != '1))
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (r_read && stall && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random stimulus,
// all observed traffic checked against a transaction-level fetch model.
module tb_if_fetch_unit;

  localparam int          TNUM     = 21;
  localparam int          INUM     = 26 - TNUM;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk;
  logic            rst;
  logic [TNUM-1:0] tag_C_L1;
  logic [INUM-1:0] index_C_L1;
  logic [5:0]      offset;
  logic            read_C_L1;
  logic            flush;
  logic            stall;
  logic [31:0]     read_data_L1_C;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [31:0]     inst_pc;
  logic [31:0]     addr;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: next address the cache should see, next PC decode should
  // receive, and requests accepted but not yet consumed by decode.
  logic [31:0] m_req  = 32'h0;
  logic [31:0] m_pop  = 32'h0;
  int          m_out  = 0;
  int          n_acc  = 0;
  int          n_pop  = 0;
  int          n_pop_tot = 0;
  logic        p_redir = 1'b0;
  logic        p_hold  = 1'b0;
  logic [31:0] p_addr  = 32'h0;
  logic        g_have  = 1'b0;
  logic [31:0] g_addr  = 32'h0;

  if_fetch_unit #(
    .TNUM     (TNUM),
    .INUM     (INUM),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tag_C_L1       (tag_C_L1),
    .index_C_L1     (index_C_L1),
    .offset         (offset),
    .read_C_L1      (read_C_L1),
    .flush          (flush),
    .stall          (stall),
    .read_data_L1_C (read_data_L1_C),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  assign addr = {tag_C_L1, index_C_L1, offset};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] cache_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  // Cache model: the word for an accepted address appears the next cycle;
  // every other cycle carries junk that must never reach decode.
  initial begin
    read_data_L1_C = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      read_data_L1_C = g_have ? cache_word(g_addr) : $urandom();
    end
  end

  // Monitor: inspects each cycle mid-period and applies what the coming
  // edge does (accept, pop, redirect, reset) to the model.
  always @(negedge clk) begin
    if (rst) begin
      m_req   = RESET_PC;
      m_pop   = RESET_PC;
      m_out   = 0;
      n_acc   = 0;
      n_pop   = 0;
      p_redir = 1'b0;
      p_hold  = 1'b0;
      g_have  = 1'b0;
    end else begin
      chk_val("flush", flush, p_redir);
      if (p_redir) begin
        chk_val("flush_rd", read_C_L1, 1'b0);
        chk_val("flush_vld", inst_valid, 1'b0);
      end
      if (p_hold) begin
        chk_val("hold_addr", addr, p_addr);
        chk_val("hold_rd", read_C_L1, 1'b1);
      end
      if (redirect_valid) begin
        m_req = redirect_pc & ~32'h3;
        m_pop = redirect_pc & ~32'h3;
        m_out = 0;
      end else begin
        if (read_C_L1 && !stall) begin
          chk_val("credit", (m_out < QDEPTH), 1'b1);
          chk_val("req_addr", addr, m_req);
          m_req = m_req + 32'd4;
          m_out++;
          n_acc++;
        end
        if (inst_valid && inst_ready) begin
          chk_val("pop_pc", inst_pc, m_pop);
          chk_val("pop_data", inst_data, cache_word(m_pop));
          m_pop = m_pop + 32'd4;
          m_out--;
          n_pop++;
          n_pop_tot++;
        end
      end
      g_have  = read_C_L1 && !stall;
      g_addr  = addr;
      p_redir = redirect_valid;
      p_hold  = read_C_L1 && stall && !redirect_valid;
      p_addr  = addr;
    end
  end

  initial begin
    int found;
    int pop_start;

    // Reset with a redirect asserted alongside: reset must win.
    rst = 1'b1; stall = 1'b0; inst_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    cyc(); cyc(); cyc();
    rst = 1'b0; redirect_valid = 1'b0;
    smp();
    chk_val("rst_rd", read_C_L1, 1'b0);
    chk_val("rst_flush", flush, 1'b0);
    chk_val("rst_vld", inst_valid, 1'b0);
    chk_val("rst_data", inst_data, 32'h0);
    chk_val("rst_pc", inst_pc, 32'h0);
    chk_val("rst_addr", addr, RESET_PC);
    cyc(); smp();
    chk_val("rd_2nd", read_C_L1, 1'b1);
    chk_val("first_addr", addr, RESET_PC);
    repeat (12) cyc();
    smp();
    chk_val("stream_pops", (n_pop >= 6), 1'b1);

    // Decode never ready: exactly QDEPTH requests, then fetching pauses.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; inst_ready = 1'b0;
    repeat (15) cyc();
    smp();
    chk_val("acc_full", n_acc, QDEPTH);
    chk_val("full_rd", read_C_L1, 1'b0);
    chk_val("full_vld", inst_valid, 1'b1);
    chk_val("full_head", inst_pc, 32'h0);
    cyc(); inst_ready = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      smp();
      if (read_C_L1) begin
        found = 1;
        chk_val("resume_addr", addr, 32'h10);
      end else begin
        cyc();
      end
    end
    chk_val("resume_seen", found, 1);

    // Long stall on the last word of a line, then cross into the next line.
    cyc(); stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1A3C;
    cyc(); redirect_valid = 1'b0;
    smp();
    chk_val("st_flush", flush, 1'b1);
    repeat (10) begin
      cyc(); smp();
      chk_val("st_off", offset, 6'h3C);
      chk_val("st_idx", index_C_L1, 5'd8);
      chk_val("st_addr", addr, 32'h0000_1A3C);
      chk_val("st_rd", read_C_L1, 1'b1);
    end
    cyc(); stall = 1'b0;
    smp();
    chk_val("rel_addr", addr, 32'h0000_1A3C);
    cyc(); smp();
    chk_val("line_off", offset, 6'h00);
    chk_val("line_idx", index_C_L1, 5'd9);
    chk_val("line_rd", read_C_L1, 1'b1);

    // Redirect while a response is in flight.
    cyc(); smp();
    chk_val("pre_redir_rd", read_C_L1, 1'b1);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    cyc(); redirect_valid = 1'b0;
    smp();
    chk_val("rd_flush", flush, 1'b1);
    cyc(); smp();
    chk_val("rd_flush_end", flush, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      cyc(); smp();
      if (inst_valid) begin
        found = 1;
        chk_val("redir_first_pc", inst_pc, 32'h0000_1000);
      end
    end
    chk_val("redir_seen", found, 1);

    // Wrap through the top of the address space; low target bits ignored.
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF6;
    cyc(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      smp();
      if (read_C_L1 && !stall && addr == 32'hFFFF_FFFC) found = 1;
      else cyc();
    end
    chk_val("wrap_seen", found, 1);
    cyc(); smp();
    chk_val("wrap_addr", addr, 32'h0000_0000);
    chk_val("wrap_rd", read_C_L1, 1'b1);

    // Build a backlog, then stream with push and pop on the same cycle.
    cyc(); inst_ready = 1'b0;
    cyc(); cyc(); inst_ready = 1'b1;
    repeat (8) begin
      cyc(); smp();
      chk_val("pp_vld", inst_valid, 1'b1);
    end

    // Random traffic.
    pop_start = n_pop_tot;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst            = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom();
        1:       redirect_pc = 32'hFFFF_FFE0 | ($urandom() & 32'h1F);
        default: redirect_pc = $urandom() & 32'h0000_0FFF;
      endcase
      stall      = ($urandom_range(0, 9) < 3);
      inst_ready = ($urandom_range(0, 9) < 6);
    end
    cyc();
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0; inst_ready = 1'b1;
    repeat (10) cyc();
    smp();
    chk_val("rand_pops", ((n_pop_tot - pop_start) > 200), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the L1 instruction cache. Holds the PC and splits it into tag/index/offset. Issues one 32-bit fetch per accepted request, buffers returned instructions in a small FIFO and hands them to decode over a valid/ready handshake. Handles branch redirects by flushing its queue and the cache request.

Parameters:
TNUM, 21, tag width (PC[31:32-TNUM])
INUM, 26-TNUM, index width (PC[31-TNUM:6])
QDEPTH, 4, fetch-queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
tag_C_L1  out  TNUM  PC tag field
index_C_L1  out  INUM  PC index field
offset  out  6  PC[5:0], byte offset in 64-byte line
read_C_L1  out  1  fetch request to L1I
flush  out  1  one-cycle flush pulse to L1I on redirect
stall  in  1  L1I busy/miss; request not accepted while high
read_data_L1_C  in  32  instruction, valid 1 cycle after acceptance
redirect_valid  in  1  branch/exception redirect
redirect_pc  in  32  redirect target (word aligned)
inst_valid  out  1  queue head valid
inst_ready  in  1  decode accepts head
inst_data  out  32  queue head instruction
inst_pc  out  32  PC of queue head

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, queue empty, no response pending, state S_IDLE. Outputs: read_C_L1=0, flush=0, inst_valid=0, inst_data=0, inst_pc=0, tag/index/offset taken from RESET_PC.
- Acceptance: a request completes on a cycle with read_C_L1=1 and stall=0. Address outputs are held stable while stall=1.
- Response latency: read_data_L1_C is captured exactly 1 cycle after acceptance (resp_pend flag). The entry written is {pc_of_request, data}.
- Credit: a request is issued only if count + resp_pend + 1 <= QDEPTH, so a returning response never overflows the queue.
- FSM:
  - S_IDLE: one cycle after reset, no request; then go to S_REQ.
  - S_REQ: read_C_L1=1. On acceptance, pc<=pc+4. Stay in S_REQ if credit remains after this fetch, else go to S_HOLD.
  - S_HOLD: read_C_L1=0; return to S_REQ when credit is available.
- PC wraps 32'hFFFF_FFFC -> 0. Crossing into a new line (offset 0x3C -> 0x00) needs no special handling; it is a new tag/index.
- Queue: circular FIFO with log2(QDEPTH)-bit pointers and a count.
  - Push and pop in the same cycle: count unchanged.
  - The head is presented combinationally from registers; inst_valid = (count != 0).
- Redirect (highest priority, any state):
  - Next cycle: pc<=redirect_pc, queue cleared, resp_pend cleared, flush=1 for exactly that one cycle, read_C_L1=0 during it, then S_REQ.
  - A response arriving in the cycle after redirect is discarded.
  - A pop on the redirect cycle is ignored.
  - redirect_pc[1:0] is ignored (forced to 0).
- Redirect during stall=1: the request is abandoned; the cache sees flush.
- rst has priority over redirect.

Optional Feature:
Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_fetch_cnt increments on each accepted request.
  - perf_stall_cnt increments on each cycle with read_C_L1=1 and stall=1.
  - Both saturate at 32'hFFFF_FFFF and are not cleared by redirect.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package if_pkg: state encoding (S_IDLE, S_REQ, S_HOLD), INST_W=32, PC_W=32, PC_STEP=4, and the queue entry struct {pc, inst}.
- One sub-module, if_fetch_queue: parameterised FIFO with push/pop/clear, count output, and registered head.
- The FSM, PC and credit logic stay in the top.

Test Plan:
- Reset, stall=0, inst_ready=1 -> read_C_L1 rises the 2nd cycle; inst_pc sequence 0x0,0x4,0x8…; inst_data equals the cache model word.
- inst_ready=0 throughout -> exactly 4 requests accepted, then read_C_L1=0; count=4, no overflow. inst_ready=1 -> fetching resumes at 0x10.
- stall=1 for 10 cycles at pc=0x3C -> tag/index/offset held (offset 0x3C); after release, the next request is offset 0x00 with index+1.
- redirect_valid with redirect_pc=0x1000 while a response is pending -> flush pulse of 1 cycle; the stale word is dropped; first inst_pc=0x1000.
- PC at 0xFFFF_FFFC -> next fetch address 0x0000_0000.
- Simultaneous push and pop at count=2 -> count stays 2; FIFO order preserved. rst asserted together with redirect -> pc=RESET_PC.
